decode_ctrl_pipe: RTL and testbench

Registered main-control decoder for the pipelined RV32I core. Decodes the 7-bit opcode in the Decode stage into the full control bundle and holds it in the ID/EX control register with stall, flush and valid handling. Extends the single-cycle decoder with U-type and JALR support, defined zero outputs for illegal opcodes, and a saturating illegal-instruction counter.

---
 rtl/decode_ctrl_pipe.sv | 173 +++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// Registered RV32I main-control decoder: decodes the Decode-stage opcode and holds the
// control bundle in the ID/EX register with stall, flush, valid and illegal-op counting.
module decode_ctrl_pipe #(
    parameter bit EN_UPPER = 1'b1,
    parameter bit EN_JALR  = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [6:0]       i_op_d,
    input  logic             i_valid_d,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic             i_clr_cnt,
    output logic             o_valid_e,
    output logic             o_reg_write_e,
    output logic             o_mem_write_e,
    output logic             o_branch_e,
    output logic             o_jump_e,
    output logic             o_jalr_e,
    output logic             o_alu_src_b_e,
    output logic [1:0]       o_alu_src_a_e,
    output logic [1:0]       o_result_src_e,
    output logic [2:0]       o_imm_src_e,
    output logic [1:0]       o_alu_op_e,
    output logic             o_illegal_e,
    output logic [CNT_W-1:0] o_illegal_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src_b;
        logic [1:0] alu_src_a;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    ctrl_t            w_dec;
    ctrl_t            r_ctrl;
    logic             w_count_illegal;
    logic [CNT_W-1:0] r_cnt;

    // A bubble in Decode decodes to all zeros, so it can never look illegal.
    always_comb begin
        w_dec = '0;
        if (i_valid_d) begin
            w_dec.valid = 1'b1;
            case (i_op_d)
                OP_LOAD: begin
                    w_dec.reg_write  = 1'b1;
                    w_dec.alu_src_b  = 1'b1;
                    w_dec.result_src = 2'b01;
                end
                OP_STORE: begin
                    w_dec.mem_write = 1'b1;
                    w_dec.alu_src_b = 1'b1;
                    w_dec.imm_src   = 3'b001;
                end
                OP_RTYPE: begin
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_op    = 2'b10;
                end
                OP_IALU: begin
                    w_dec.reg_write = 1'b1;
                    w_dec.alu_src_b = 1'b1;
                    w_dec.alu_op    = 2'b10;
                end
                OP_BRANCH: begin
                    w_dec.branch  = 1'b1;
                    w_dec.imm_src = 3'b010;
                    w_dec.alu_op  = 2'b01;
                end
                OP_JAL: begin
                    w_dec.reg_write  = 1'b1;
                    w_dec.jump       = 1'b1;
                    w_dec.imm_src    = 3'b011;
                    w_dec.result_src = 2'b10;
                end
                OP_JALR: begin
                    if (EN_JALR) begin
                        w_dec.reg_write  = 1'b1;
                        w_dec.jump       = 1'b1;
                        w_dec.jalr       = 1'b1;
                        w_dec.alu_src_b  = 1'b1;
                        w_dec.result_src = 2'b10;
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end
                OP_LUI: begin
                    if (EN_UPPER) begin
                        w_dec.reg_write = 1'b1;
                        w_dec.alu_src_b = 1'b1;
                        w_dec.alu_src_a = 2'b10;
                        w_dec.imm_src   = 3'b100;
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end
                OP_AUIPC: begin
                    if (EN_UPPER) begin
                        w_dec.reg_write = 1'b1;
                        w_dec.alu_src_b = 1'b1;
                        w_dec.alu_src_a = 2'b01;
                        w_dec.imm_src   = 3'b100;
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end
                default: begin
                    w_dec.illegal = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ctrl <= '0;
        end else if (i_flush) begin
            r_ctrl <= '0;
        end else if (i_en) begin
            r_ctrl <= w_dec;
        end
    end

    // Only a genuine load counts, so held or flushed instructions are never re-counted.
    assign w_count_illegal = i_en && !i_flush && w_dec.illegal;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr_cnt) begin
            r_cnt <= '0;
        end else if (w_count_illegal && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_valid_e      = r_ctrl.valid;
    assign o_reg_write_e  = r_ctrl.reg_write;
    assign o_mem_write_e  = r_ctrl.mem_write;
    assign o_branch_e     = r_ctrl.branch;
    assign o_jump_e       = r_ctrl.jump;
    assign o_jalr_e       = r_ctrl.jalr;
    assign o_alu_src_b_e  = r_ctrl.alu_src_b;
    assign o_alu_src_a_e  = r_ctrl.alu_src_a;
    assign o_result_src_e = r_ctrl.result_src;
    assign o_imm_src_e    = r_ctrl.imm_src;
    assign o_alu_op_e     = r_ctrl.alu_op;
    assign o_illegal_e    = r_ctrl.illegal;
    assign o_illegal_cnt  = r_cnt;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench for decode_ctrl_pipe: three instances (default, 2-bit counter,
// upper/JALR disabled) share one stimulus stream; expectations are queued per cycle.
module tb_decode_ctrl_pipe;

    logic       clk;
    logic       rstN;
    logic [6:0] opD;
    logic       validD;
    logic       en;
    logic       flush;
    logic       clrCnt;

    logic [2:0]      valE, rwE, mwE, brE, jpE, jrE, asbE, illE;
    logic [2:0][1:0] asaE, rsE, aopE;
    logic [2:0][2:0] immE;
    logic [7:0]      cnt0, cnt2;
    logic [1:0]      cnt1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [16:0] bundle;
        int          cnt;
    } sbEntry_t;

    sbEntry_t sbQ[$];
    sbEntry_t sb;

    logic [16:0] expLoad, expStore, expR, expI, expBr, expJal, expJalr, expLui, expAuipc;
    logic [16:0] expIll;

    decode_ctrl_pipe #(.EN_UPPER(1'b1), .EN_JALR(1'b1), .CNT_W(8)) dut0 (
        .i_clk(clk), .i_rst_n(rstN), .i_op_d(opD), .i_valid_d(validD), .i_en(en),
        .i_flush(flush), .i_clr_cnt(clrCnt),
        .o_valid_e(valE[0]), .o_reg_write_e(rwE[0]), .o_mem_write_e(mwE[0]),
        .o_branch_e(brE[0]), .o_jump_e(jpE[0]), .o_jalr_e(jrE[0]), .o_alu_src_b_e(asbE[0]),
        .o_alu_src_a_e(asaE[0]), .o_result_src_e(rsE[0]), .o_imm_src_e(immE[0]),
        .o_alu_op_e(aopE[0]), .o_illegal_e(illE[0]), .o_illegal_cnt(cnt0)
    );

    decode_ctrl_pipe #(.EN_UPPER(1'b1), .EN_JALR(1'b1), .CNT_W(2)) dut1 (
        .i_clk(clk), .i_rst_n(rstN), .i_op_d(opD), .i_valid_d(validD), .i_en(en),
        .i_flush(flush), .i_clr_cnt(clrCnt),
        .o_valid_e(valE[1]), .o_reg_write_e(rwE[1]), .o_mem_write_e(mwE[1]),
        .o_branch_e(brE[1]), .o_jump_e(jpE[1]), .o_jalr_e(jrE[1]), .o_alu_src_b_e(asbE[1]),
        .o_alu_src_a_e(asaE[1]), .o_result_src_e(rsE[1]), .o_imm_src_e(immE[1]),
        .o_alu_op_e(aopE[1]), .o_illegal_e(illE[1]), .o_illegal_cnt(cnt1)
    );

    decode_ctrl_pipe #(.EN_UPPER(1'b0), .EN_JALR(1'b0), .CNT_W(8)) dut2 (
        .i_clk(clk), .i_rst_n(rstN), .i_op_d(opD), .i_valid_d(validD), .i_en(en),
        .i_flush(flush), .i_clr_cnt(clrCnt),
        .o_valid_e(valE[2]), .o_reg_write_e(rwE[2]), .o_mem_write_e(mwE[2]),
        .o_branch_e(brE[2]), .o_jump_e(jpE[2]), .o_jalr_e(jrE[2]), .o_alu_src_b_e(asbE[2]),
        .o_alu_src_a_e(asaE[2]), .o_result_src_e(rsE[2]), .o_imm_src_e(immE[2]),
        .o_alu_op_e(aopE[2]), .o_illegal_e(illE[2]), .o_illegal_cnt(cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [16:0] mk(input bit v, rw, mw, br, jp, jr, asb,
                                       input bit [1:0] asa, rs, input bit [2:0] imm,
                                       input bit [1:0] aop, input bit ill);
        return {v, rw, mw, br, jp, jr, asb, asa, rs, imm, aop, ill};
    endfunction

    function automatic logic [16:0] packOut(input int k);
        return {valE[k], rwE[k], mwE[k], brE[k], jpE[k], jrE[k], asbE[k],
                asaE[k], rsE[k], immE[k], aopE[k], illE[k]};
    endfunction

    // Drive one cycle of inputs, queue dut0's expectation, and step past the edge.
    task automatic applyStimulus(input logic [6:0] op, input logic v, e, f, c, r,
                                 input logic [16:0] expB, input int expC);
        sbEntry_t ent;
        opD = op; validD = v; en = e; flush = f; clrCnt = c; rstN = r;
        ent.bundle = expB;
        ent.cnt = expC;
        sbQ.push_back(ent);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(7'b0110011, 1, 1, 0, 0, 0, '0, 0);
            sb = sbQ.pop_front();
            checks++;
            if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
                errors++;
                $display("[TB] FAIL reset_dut0: got %h/%0d expected %h/%0d", packOut(0), cnt0, sb.bundle, sb.cnt);
            end
        end
        checks++;
        if (packOut(1) !== 17'h0 || packOut(2) !== 17'h0 || cnt1 !== 2'd0 || cnt2 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_others: got %h %h %0d %0d expected all zero", packOut(1), packOut(2), cnt1, cnt2);
        end
        applyStimulus(7'b0110011, 1, 1, 0, 0, 1, expR, 0);
        sb = sbQ.pop_front();
        checks++;
        if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h/%0d expected %h/%0d", packOut(0), cnt0, sb.bundle, sb.cnt);
        end
    endtask

    task automatic test_legal_sweep();
        logic [6:0]  ops  [9];
        logic [16:0] exps [9];
        logic        dis  [9];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        exps = '{expLoad, expStore, expR, expI, expBr, expJal, expJalr, expLui, expAuipc};
        dis = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(ops[i], 1, 1, 0, 0, 1, exps[i], 0);
            sb = sbQ.pop_front();
            checks++;
            if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
                errors++;
                $display("[TB] FAIL sweep_op_%b: got %h/%0d expected %h/%0d", ops[i], packOut(0), cnt0, sb.bundle, sb.cnt);
            end
            checks++;
            if (packOut(2) !== (dis[i] ? expIll : exps[i])) begin
                errors++;
                $display("[TB] FAIL sweep_dis_op_%b: got %h expected %h", ops[i], packOut(2), dis[i] ? expIll : exps[i]);
            end
        end
    endtask

    task automatic test_illegal_count();
        applyStimulus(7'b0110011, 1, 1, 0, 1, 1, expR, 0);
        sb = sbQ.pop_front();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(7'b1110011, 1, 1, 0, 0, 1, expIll, k);
            sb = sbQ.pop_front();
            checks++;
            if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
                errors++;
                $display("[TB] FAIL illegal_%0d: got %h/%0d expected %h/%0d", k, packOut(0), cnt0, sb.bundle, sb.cnt);
            end
        end
        applyStimulus(7'b1110011, 1, 1, 0, 1, 1, expIll, 0);
        sb = sbQ.pop_front();
        checks++;
        if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
            errors++;
            $display("[TB] FAIL clr_wins: got %h/%0d expected %h/%0d", packOut(0), cnt0, sb.bundle, sb.cnt);
        end
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(7'b0000000, 1, 1, 0, 0, 1, expIll, k);
            sb = sbQ.pop_front();
            checks++;
            if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
                errors++;
                $display("[TB] FAIL sat_dut0_%0d: got %h/%0d expected %h/%0d", k, packOut(0), cnt0, sb.bundle, sb.cnt);
            end
            checks++;
            if (cnt1 !== ((k > 3) ? 2'd3 : 2'(k))) begin
                errors++;
                $display("[TB] FAIL sat_cnt2bit_%0d: got %0d expected %0d", k, cnt1, (k > 3) ? 3 : k);
            end
        end
    endtask

    task automatic test_stall();
        logic [6:0] stallOps [4];
        stallOps = '{7'b1110011, 7'b0110011, 7'b1101111, 7'b0000000};
        applyStimulus(7'b0100011, 1, 1, 0, 0, 1, expStore, 5);
        sb = sbQ.pop_front();
        checks++;
        if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
            errors++;
            $display("[TB] FAIL stall_load: got %h/%0d expected %h/%0d", packOut(0), cnt0, sb.bundle, sb.cnt);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(stallOps[i], 1, 0, 0, 0, 1, expStore, 5);
            sb = sbQ.pop_front();
            checks++;
            if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got %h/%0d expected %h/%0d", i, packOut(0), cnt0, sb.bundle, sb.cnt);
            end
        end
        applyStimulus(7'b1110011, 1, 0, 1, 0, 1, '0, 5);
        sb = sbQ.pop_front();
        checks++;
        if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
            errors++;
            $display("[TB] FAIL flush_in_stall: got %h/%0d expected %h/%0d", packOut(0), cnt0, sb.bundle, sb.cnt);
        end
        applyStimulus(7'b1110011, 1, 1, 1, 0, 1, '0, 5);
        sb = sbQ.pop_front();
        checks++;
        if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
            errors++;
            $display("[TB] FAIL flush_no_count: got %h/%0d expected %h/%0d", packOut(0), cnt0, sb.bundle, sb.cnt);
        end
    endtask

    task automatic test_valid_low();
        applyStimulus(7'b1110011, 0, 1, 0, 0, 1, '0, 5);
        sb = sbQ.pop_front();
        checks++;
        if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
            errors++;
            $display("[TB] FAIL valid_low: got %h/%0d expected %h/%0d", packOut(0), cnt0, sb.bundle, sb.cnt);
        end
    endtask

    task automatic test_disabled();
        logic [6:0]  ops  [2];
        logic [16:0] exps [2];
        ops = '{7'b0110111, 7'b1100111};
        exps = '{expLui, expJalr};
        applyStimulus(7'b0000000, 0, 1, 0, 1, 1, '0, 0);
        sb = sbQ.pop_front();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(ops[i], 1, 1, 0, 0, 1, exps[i], 0);
            sb = sbQ.pop_front();
            checks++;
            if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
                errors++;
                $display("[TB] FAIL dis_dut0_%b: got %h/%0d expected %h/%0d", ops[i], packOut(0), cnt0, sb.bundle, sb.cnt);
            end
            checks++;
            if (packOut(2) !== expIll || cnt2 !== 8'(i + 1)) begin
                errors++;
                $display("[TB] FAIL dis_dut2_%b: got %h/%0d expected %h/%0d", ops[i], packOut(2), cnt2, expIll, i + 1);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int k = 1; k <= 2; k++) begin
            applyStimulus(7'b1111111, 1, 1, 0, 0, 1, expIll, k);
            sb = sbQ.pop_front();
            checks++;
            if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
                errors++;
                $display("[TB] FAIL pre_reset_%0d: got %h/%0d expected %h/%0d", k, packOut(0), cnt0, sb.bundle, sb.cnt);
            end
        end
        applyStimulus(7'b1111111, 1, 0, 1, 1, 0, '0, 0);
        sb = sbQ.pop_front();
        checks++;
        if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %h/%0d expected %h/%0d", packOut(0), cnt0, sb.bundle, sb.cnt);
        end
        applyStimulus(7'b0000011, 1, 0, 0, 0, 1, '0, 0);
        sb = sbQ.pop_front();
        checks++;
        if (packOut(0) !== sb.bundle || cnt0 !== sb.cnt[7:0]) begin
            errors++;
            $display("[TB] FAIL post_reset_hold: got %h/%0d expected %h/%0d", packOut(0), cnt0, sb.bundle, sb.cnt);
        end
    endtask

    initial begin
        expLoad  = mk(1, 1, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b000, 2'b00, 0);
        expStore = mk(1, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 3'b001, 2'b00, 0);
        expR     = mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b10, 0);
        expI     = mk(1, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b10, 0);
        expBr    = mk(1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 2'b01, 0);
        expJal   = mk(1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b10, 3'b011, 2'b00, 0);
        expJalr  = mk(1, 1, 0, 0, 1, 1, 1, 2'b00, 2'b10, 3'b000, 2'b00, 0);
        expLui   = mk(1, 1, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b100, 2'b00, 0);
        expAuipc = mk(1, 1, 0, 0, 0, 0, 1, 2'b01, 2'b00, 3'b100, 2'b00, 0);
        expIll   = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 1);

        opD = '0; validD = 0; en = 0; flush = 0; clrCnt = 0; rstN = 0;

        test_reset();
        test_legal_sweep();
        test_illegal_count();
        test_saturation();
        test_stall();
        test_valid_low();
        test_disabled();
        test_mid_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
